// File: rtl/hazard_ctrl_unit.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_unit
//
// Pipeline hazard controller. It watches the ID/EX load destination against
// the IF/ID source registers, the MEM-stage branch resolution and the
// data-memory handshake. From these it drives the PC / IF/ID write enables and
// the IF/ID, ID/EX and EX/MEM flush inputs.
//
// Optional feature macro: HAZARD_PERF_CNT_EN
//   When defined, three wrapping DATA_WIDTH-bit performance counters are added:
//   stall_cnt_o, flush_cnt_o and freeze_cnt_o. When undefined, those ports and
//   registers do not exist and all other behaviour is unchanged.
//
// Parameters
//   DATA_WIDTH     width of the optional performance counters
//   BRANCH_PENALTY cycles the IF/ID + ID/EX flush is held after a taken branch (1..7)
//   MAX_MEM_WAIT   freeze cycles after which mem_timeout_o is set (1..255)
//
// Ports
//   clock, reset        pipeline clock, asynchronous active-low reset
//   idex_memRead_i      memRead held in ID/EX
//   idex_Rd_i           destination register held in ID/EX
//   ifid_Rn_i/Rm_i      source registers of the instruction in IF/ID
//   ifid_usesRm_i       instruction in IF/ID reads Rm
//   branch_taken_i      taken branch resolved in MEM (one-cycle pulse)
//   dmem_req_i          EX/MEM has a data-memory access active
//   dmem_ready_i        data memory completed the access
//   pc_write_o          PC update enable
//   ifid_write_o        IF/ID load enable
//   ifid_flush_o        IF/ID clear
//   idex_flush_o        ID/EX clear
//   exmem_flush_o       EX/MEM clear
//   mem_timeout_o       sticky: a memory wait reached MAX_MEM_WAIT cycles
//   state_o             FSM state (debug)
//
// State table
//   RUN        | normal flow; detects freeze, taken branch and load-use
//   LOAD_STALL | cycle after a load-use bubble; load-use masked
//   BR_FLUSH   | remainder of the taken-branch flush window
//   MEM_WAIT   | whole pipeline frozen until data memory is ready
// -----------------------------------------------------------------------------
module hazard_ctrl_unit #(
    parameter int DATA_WIDTH     = 64,
    parameter int BRANCH_PENALTY = 1,
    parameter int MAX_MEM_WAIT   = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       idex_memRead_i,
    input  logic [4:0] idex_Rd_i,
    input  logic [4:0] ifid_Rn_i,
    input  logic [4:0] ifid_Rm_i,
    input  logic       ifid_usesRm_i,
    input  logic       branch_taken_i,
    input  logic       dmem_req_i,
    input  logic       dmem_ready_i,
    output logic       pc_write_o,
    output logic       ifid_write_o,
    output logic       ifid_flush_o,
    output logic       idex_flush_o,
    output logic       exmem_flush_o,
    output logic       mem_timeout_o,
    output logic [1:0] state_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [DATA_WIDTH-1:0] stall_cnt_o,
    output logic [DATA_WIDTH-1:0] flush_cnt_o,
    output logic [DATA_WIDTH-1:0] freeze_cnt_o
`endif
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        BR_FLUSH   = 2'd2,
        MEM_WAIT   = 2'd3
    } state_t;

    localparam logic [2:0] BR_RELOAD  = 3'(BRANCH_PENALTY - 1);
    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_MEM_WAIT);

    state_t     state_q, state_d;
    logic [2:0] flush_cnt_q, flush_cnt_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       timeout_q, timeout_d;

    logic       lu_hit;
    logic       mem_stall;
    logic [7:0] wait_inc;

    logic       pc_w, ifid_w, ifid_f, idex_f, exmem_f;

    // XZR (register 31) never creates a dependency.
    assign lu_hit = idex_memRead_i && (idex_Rd_i != 5'd31) &&
                    ((idex_Rd_i == ifid_Rn_i) ||
                     (ifid_usesRm_i && (idex_Rd_i == ifid_Rm_i)));

    assign mem_stall = dmem_req_i && !dmem_ready_i;
    assign wait_inc  = (wait_cnt_q == 8'hFF) ? 8'hFF : wait_cnt_q + 8'd1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            flush_cnt_q <= 3'd0;
            wait_cnt_q  <= 8'd0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        timeout_d   = timeout_q;
        pc_w        = 1'b1;
        ifid_w      = 1'b1;
        ifid_f      = 1'b0;
        idex_f      = 1'b0;
        exmem_f     = 1'b0;

        case (state_q)
            RUN, LOAD_STALL: begin
                state_d = RUN;
                if (mem_stall) begin
                    // The cycle that sees the miss is the first frozen cycle.
                    pc_w       = 1'b0;
                    ifid_w     = 1'b0;
                    wait_cnt_d = wait_inc;
                    if (wait_inc == WAIT_LIMIT) timeout_d = 1'b1;
                    state_d    = MEM_WAIT;
                end else if (branch_taken_i) begin
                    ifid_f      = 1'b1;
                    idex_f      = 1'b1;
                    exmem_f     = 1'b1;
                    flush_cnt_d = BR_RELOAD;
                    state_d     = (BRANCH_PENALTY > 1) ? BR_FLUSH : RUN;
                end else if (lu_hit && (state_q == RUN)) begin
                    // ID/EX still shows the same load next cycle; LOAD_STALL masks it.
                    pc_w    = 1'b0;
                    ifid_w  = 1'b0;
                    idex_f  = 1'b1;
                    state_d = LOAD_STALL;
                end
            end

            BR_FLUSH: begin
                ifid_f = 1'b1;
                idex_f = 1'b1;
                if (branch_taken_i) begin
                    flush_cnt_d = BR_RELOAD;
                end else if (flush_cnt_q <= 3'd1) begin
                    flush_cnt_d = 3'd0;
                    state_d     = RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q - 3'd1;
                end
            end

            MEM_WAIT: begin
                // A dropped request also releases so the freeze cannot wedge.
                if (dmem_ready_i || !dmem_req_i) begin
                    wait_cnt_d = 8'd0;
                    state_d    = RUN;
                end else begin
                    pc_w       = 1'b0;
                    ifid_w     = 1'b0;
                    wait_cnt_d = wait_inc;
                    if (wait_inc == WAIT_LIMIT) timeout_d = 1'b1;
                end
            end

            default: state_d = RUN;
        endcase
    end

    // Reset forces the safe output values combinationally, independent of the clock.
    assign pc_write_o    = reset & pc_w;
    assign ifid_write_o  = reset & ifid_w;
    assign ifid_flush_o  = ~reset | ifid_f;
    assign idex_flush_o  = ~reset | idex_f;
    assign exmem_flush_o = ~reset | exmem_f;
    assign mem_timeout_o = timeout_q;
    assign state_o       = state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [DATA_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [DATA_WIDTH-1:0] flush_cnt_pq, flush_cnt_pd;
    logic [DATA_WIDTH-1:0] freeze_cnt_q, freeze_cnt_d;

    // Only the load-use bubble flushes ID/EX without IF/ID; only a freeze
    // holds the PC without any flush.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_pd = flush_cnt_pq;
        freeze_cnt_d = freeze_cnt_q;
        if (idex_f && !ifid_f) stall_cnt_d  = stall_cnt_q + DATA_WIDTH'(1);
        if (ifid_f)            flush_cnt_pd = flush_cnt_pq + DATA_WIDTH'(1);
        if (!pc_w && !idex_f)  freeze_cnt_d = freeze_cnt_q + DATA_WIDTH'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cnt_q  <= '0;
            flush_cnt_pq <= '0;
            freeze_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_pq <= flush_cnt_pd;
            freeze_cnt_q <= freeze_cnt_d;
        end
    end

    assign stall_cnt_o  = stall_cnt_q;
    assign flush_cnt_o  = flush_cnt_pq;
    assign freeze_cnt_o = freeze_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl_unit
//
// Self-checking bench for hazard_ctrl_unit (BRANCH_PENALTY=3, MAX_MEM_WAIT=15,
// performance counters not built). A cycle-level behavioural model tracks the
// pipeline situation (frozen, flush cycles left, bubble just inserted, freeze
// cycles so far) and predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl_unit;

    localparam int BP = 3;
    localparam int MW = 15;

    logic       clock = 1'b0;
    logic       reset;
    logic       idex_memRead_i;
    logic [4:0] idex_Rd_i, ifid_Rn_i, ifid_Rm_i;
    logic       ifid_usesRm_i, branch_taken_i, dmem_req_i, dmem_ready_i;
    logic       pc_write_o, ifid_write_o, ifid_flush_o, idex_flush_o, exmem_flush_o;
    logic       mem_timeout_o;
    logic [1:0] state_o;

    always #5 clock = ~clock;

    hazard_ctrl_unit #(
        .DATA_WIDTH    (64),
        .BRANCH_PENALTY(BP),
        .MAX_MEM_WAIT  (MW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .idex_memRead_i(idex_memRead_i),
        .idex_Rd_i     (idex_Rd_i),
        .ifid_Rn_i     (ifid_Rn_i),
        .ifid_Rm_i     (ifid_Rm_i),
        .ifid_usesRm_i (ifid_usesRm_i),
        .branch_taken_i(branch_taken_i),
        .dmem_req_i    (dmem_req_i),
        .dmem_ready_i  (dmem_ready_i),
        .pc_write_o    (pc_write_o),
        .ifid_write_o  (ifid_write_o),
        .ifid_flush_o  (ifid_flush_o),
        .idex_flush_o  (idex_flush_o),
        .exmem_flush_o (exmem_flush_o),
        .mem_timeout_o (mem_timeout_o),
        .state_o       (state_o)
    );

    int total = 0;
    int bad   = 0;

    // Model of the pipeline situation at the start of the current cycle.
    bit m_frozen, m_after_bubble, m_timeout;
    int m_fl_left, m_frz;
    bit n_frozen, n_after_bubble, n_timeout;
    int n_fl_left, n_frz;
    bit e_pc, e_ifw, e_iff, e_idf, e_exf;
    int e_state;

    function automatic bit frz_bump();
        n_frz = (m_frz >= 255) ? 255 : m_frz + 1;
        return (n_frz == MW);
    endfunction

    function void model_eval();
        bit lu;
        lu = idex_memRead_i && (idex_Rd_i != 5'd31) &&
             ((idex_Rd_i == ifid_Rn_i) || (ifid_usesRm_i && (idex_Rd_i == ifid_Rm_i)));
        e_pc = 1; e_ifw = 1; e_iff = 0; e_idf = 0; e_exf = 0;
        n_frozen = m_frozen; n_after_bubble = 0; n_timeout = m_timeout;
        n_fl_left = m_fl_left; n_frz = m_frz;
        e_state = m_frozen ? 3 : (m_fl_left > 0) ? 2 : m_after_bubble ? 1 : 0;

        if (m_frozen) begin
            if (dmem_ready_i || !dmem_req_i) begin
                n_frozen = 0;
                n_frz    = 0;
            end else begin
                e_pc = 0; e_ifw = 0;
                if (frz_bump()) n_timeout = 1;
            end
        end else if (m_fl_left > 0) begin
            e_iff = 1; e_idf = 1;
            n_fl_left = branch_taken_i ? BP - 1 : m_fl_left - 1;
        end else if (dmem_req_i && !dmem_ready_i) begin
            e_pc = 0; e_ifw = 0;
            n_frozen = 1;
            if (frz_bump()) n_timeout = 1;
        end else if (branch_taken_i) begin
            e_iff = 1; e_idf = 1; e_exf = 1;
            n_fl_left = BP - 1;
        end else if (lu && !m_after_bubble) begin
            e_pc = 0; e_ifw = 0; e_idf = 1;
            n_after_bubble = 1;
        end
    endfunction

    function void model_commit();
        m_frozen = n_frozen; m_after_bubble = n_after_bubble; m_timeout = n_timeout;
        m_fl_left = n_fl_left; m_frz = n_frz;
    endfunction

    function void model_reset();
        m_frozen = 0; m_after_bubble = 0; m_timeout = 0; m_fl_left = 0; m_frz = 0;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".pc_write"},   8'(pc_write_o),    8'd0);
        chk({tag, ".ifid_write"}, 8'(ifid_write_o),  8'd0);
        chk({tag, ".ifid_flush"}, 8'(ifid_flush_o),  8'd1);
        chk({tag, ".idex_flush"}, 8'(idex_flush_o),  8'd1);
        chk({tag, ".exmem_flush"},8'(exmem_flush_o), 8'd1);
        chk({tag, ".timeout"},    8'(mem_timeout_o), 8'd0);
        chk({tag, ".state"},      8'(state_o),       8'd0);
    endtask

    task automatic set_in(input bit mr, input int rd, input int rn, input int rm,
                          input bit urm, input bit br, input bit req, input bit rdy);
        idex_memRead_i = mr;
        idex_Rd_i      = 5'(rd);
        ifid_Rn_i      = 5'(rn);
        ifid_Rm_i      = 5'(rm);
        ifid_usesRm_i  = urm;
        branch_taken_i = br;
        dmem_req_i     = req;
        dmem_ready_i   = rdy;
    endtask

    // Called at posedge+1 with inputs applied; checks at posedge+4.
    task automatic step(input string tag);
        #3;
        model_eval();
        chk({tag, ".pc_write"},    8'(pc_write_o),    8'(e_pc));
        chk({tag, ".ifid_write"},  8'(ifid_write_o),  8'(e_ifw));
        chk({tag, ".ifid_flush"},  8'(ifid_flush_o),  8'(e_iff));
        chk({tag, ".idex_flush"},  8'(idex_flush_o),  8'(e_idf));
        chk({tag, ".exmem_flush"}, 8'(exmem_flush_o), 8'(e_exf));
        chk({tag, ".timeout"},     8'(mem_timeout_o), 8'(m_timeout));
        chk({tag, ".state"},       8'(state_o),       8'(e_state));
        @(posedge clock);
        model_commit();
        #1;
    endtask

    function automatic int pick_reg();
        int r;
        r = int'($urandom_range(0, 8));
        return (r == 8) ? 31 : r;
    endfunction

    initial begin
        reset = 1'b0;
        set_in(0, 0, 1, 2, 0, 0, 0, 1);
        model_reset();
        #2;
        chk_reset_vals("reset");
        #10 reset = 1'b1;
        @(posedge clock);
        #1;

        // Load-use on Rn: one bubble, then LOAD_STALL with normal enables, then RUN.
        set_in(1, 5, 5, 0, 0, 0, 0, 1);
        step("lu_bubble");
        step("lu_masked");
        set_in(0, 5, 5, 0, 0, 0, 0, 1);
        step("lu_run");

        // XZR and unused-Rm matches must not stall; a used Rm match must.
        set_in(1, 31, 31, 31, 1, 0, 0, 1);
        step("xzr");
        set_in(1, 7, 0, 7, 0, 0, 0, 1);
        step("rm_unused");
        set_in(1, 7, 0, 7, 1, 0, 0, 1);
        step("rm_used");
        set_in(0, 0, 1, 2, 0, 0, 0, 1);
        step("rm_after");

        // Taken branch: full flush, two IF/ID+ID/EX cycles, back to RUN.
        set_in(0, 0, 1, 2, 0, 1, 0, 1);
        step("br_c0");
        set_in(0, 0, 1, 2, 0, 0, 0, 1);
        step("br_c1");
        step("br_c2");
        step("br_c3");

        // Branch and load-use together: branch wins, no LOAD_STALL.
        set_in(1, 5, 5, 0, 0, 1, 0, 1);
        step("br_lu_c0");
        set_in(0, 5, 5, 0, 0, 0, 0, 1);
        step("br_lu_c1");
        step("br_lu_c2");
        step("br_lu_c3");

        // Slow memory: 20 cycles not ready, timeout after the 15th frozen cycle.
        set_in(0, 0, 1, 2, 0, 0, 1, 0);
        for (int i = 0; i < 20; i++) step("mem_wait");
        chk("mem_timeout_sticky", 8'(mem_timeout_o), 8'd1);
        set_in(0, 0, 1, 2, 0, 0, 1, 1);
        step("mem_release");
        set_in(0, 0, 1, 2, 0, 0, 0, 1);
        step("mem_after");

        // Reset asserted in the middle of a branch flush window.
        set_in(0, 0, 1, 2, 0, 1, 0, 1);
        step("rst_br_c0");
        set_in(0, 0, 1, 2, 0, 0, 0, 1);
        step("rst_br_c1");
        #2 reset = 1'b0;
        #1;
        chk_reset_vals("reset_mid_flush");
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        step("post_reset");

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            bit req;
            req = ($urandom_range(0, 5) == 0);
            set_in(bit'($urandom_range(0, 1)), pick_reg(), pick_reg(), pick_reg(),
                   bit'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                   req, req ? ($urandom_range(0, 2) != 0) : 1'b1);
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
